// File: rtl/fifo_ctrl_2rd.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_2rd
// Description : Pointer/flag controller that turns a 1-write / 2-read
//               register-file RAM into a FIFO with one-entry lookahead.
//               RAM read port 0 (asynchronous) always shows the head entry.
//               RAM read port 1 (synchronous) shows head+1, so a consumer
//               can pop one or two entries per cycle.
// Ports       : clk         - rising-edge clock shared with the RAM
//               reset       - synchronous, active-high reset
//               wr          - push request (data goes straight to RAM w_data)
//               rd          - pop-one request
//               rd2         - pop-two request, has precedence over rd
//               we          - RAM write enable
//               w_addr      - RAM write address (write pointer)
//               r_addr0     - RAM async read address (head pointer)
//               r_addr1     - RAM sync read address for the next cycle
//               full, empty - FIFO status
//               count       - occupancy, 0 .. 2**ADDR_WIDTH
//               peek1_valid - RAM r_data1 holds a valid head+1 entry
//               ovf, udf    - sticky overflow / underflow flags
// Macro       : FIFO_CTRL_OVF_FLAGS_EN - when defined, ovf/udf are real
//               sticky registers; otherwise both are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl_2rd #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  rd2,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr0,
    output logic [ADDR_WIDTH-1:0] r_addr1,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  peek1_valid,
    output logic                  ovf,
    output logic                  udf
);

    localparam logic [ADDR_WIDTH:0]   c_depth   = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   c_cnt_one = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   c_cnt_two = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_two = ADDR_WIDTH'(2);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_peek1_valid;

    logic                  w_pop1_ok;
    logic                  w_pop2_ok;
    logic                  w_push_ok;
    logic [ADDR_WIDTH-1:0] w_rd_step;
    logic [ADDR_WIDTH:0]   w_pop_n;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
    logic [ADDR_WIDTH-1:0] w_peek_addr;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic                  w_peek1_next;

    assign full        = (r_count == c_depth);
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign peek1_valid = r_peek1_valid;

    always_comb begin
        w_pop1_ok     = 1'b0;
        w_pop2_ok     = 1'b0;
        w_push_ok     = 1'b0;
        w_rd_step     = '0;
        w_pop_n       = '0;
        w_rd_ptr_next = r_rd_ptr;
        w_peek_addr   = r_rd_ptr;
        w_count_next  = r_count;
        w_peek1_next  = 1'b0;

        if (!reset) begin
            // A rejected rd2 swallows rd as well: the consumer asked for two.
            w_pop2_ok = rd2 & r_peek1_valid;
            w_pop1_ok = rd & ~rd2 & (r_count != '0);
            // Full FIFO can still take a push when a slot frees this edge.
            w_push_ok = wr & (~full | w_pop1_ok | w_pop2_ok);
        end

        if (w_pop2_ok) begin
            w_rd_step = c_ptr_two;
            w_pop_n   = c_cnt_two;
        end else if (w_pop1_ok) begin
            w_rd_step = c_ptr_one;
            w_pop_n   = c_cnt_one;
        end

        w_rd_ptr_next = r_rd_ptr + w_rd_step;
        w_peek_addr   = w_rd_ptr_next + c_ptr_one;
        w_count_next  = r_count + {{ADDR_WIDTH{1'b0}}, w_push_ok} - w_pop_n;

        // The sync read port returns the old word when written on the same
        // edge, so a write into the peeked slot costs one bubble cycle.
        w_peek1_next = (w_count_next >= c_cnt_two) &
                       ~(w_push_ok & (r_wr_ptr == w_peek_addr));
    end

    assign we      = w_push_ok;
    assign w_addr  = r_wr_ptr;
    assign r_addr0 = r_rd_ptr;
    assign r_addr1 = w_peek_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_peek1_valid <= 1'b0;
        end else begin
            r_wr_ptr      <= r_wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, w_push_ok};
            r_rd_ptr      <= w_rd_ptr_next;
            r_count       <= w_count_next;
            r_peek1_valid <= w_peek1_next;
        end
    end

`ifdef FIFO_CTRL_OVF_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr & ~w_push_ok) begin
                r_ovf <= 1'b1;
            end
            if ((rd | rd2) & ~(w_pop1_ok | w_pop2_ok)) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl_2rd.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl_2rd
// Description : Scoreboard bench for fifo_ctrl_2rd driving a behavioural
//               1W/2R RAM (port 0 async, port 1 sync, old data on a
//               same-edge collision). The driver applies one directed vector
//               per cycle at the falling edge and queues the hand-computed
//               expectation; the monitor samples just after the falling
//               edge and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl_2rd;

    localparam int AW = 3;
    localparam int X  = -1;

    logic          clk = 1'b0;
    logic          reset, wr, rd, rd2;
    logic          we;
    logic [AW-1:0] w_addr, r_addr0, r_addr1;
    logic          full, empty;
    logic [AW:0]   count;
    logic          peek1_valid, ovf, udf;

    logic [7:0]    w_data;
    logic [7:0]    mem [8];
    logic [7:0]    r_data0;
    logic [7:0]    r_data1;

    fifo_ctrl_2rd #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .rd2(rd2),
        .we(we), .w_addr(w_addr), .r_addr0(r_addr0), .r_addr1(r_addr1),
        .full(full), .empty(empty), .count(count),
        .peek1_valid(peek1_valid), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    assign r_data0 = mem[r_addr0];
    always @(posedge clk) begin
        if (we) mem[w_addr] <= w_data;
        r_data1 <= mem[r_addr1];
    end

    typedef struct {
        string nm;
        int    cnt;
        int    we;
        int    pk;
        int    wa;
        int    ra0;
        int    d0;
        int    d1;
        int    ovf;
        int    udf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int seq(input int n);
        return (n < 8) ? ('h30 + n) : ('h40 + n - 8);
    endfunction

    task automatic st(input string nm, input logic rs, input logic w, input logic r,
                      input logic r2, input int wd, input int cnt, input int we_e,
                      input int pk, input int wa, input int ra0, input int d0,
                      input int d1, input int ov, input int ud);
        exp_t e;
        @(negedge clk);
        reset  = rs;
        wr     = w;
        rd     = r;
        rd2    = r2;
        w_data = 8'(wd);
        e.nm = nm; e.cnt = cnt; e.we = we_e; e.pk = pk; e.wa = wa; e.ra0 = ra0;
        e.d0 = d0; e.d1 = d1; e.ovf = ov; e.udf = ud;
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.nm, " count"}, 32'(count), 32'(e.cnt));
                chk({e.nm, " full"}, 32'(full), 32'(e.cnt == 8));
                chk({e.nm, " empty"}, 32'(empty), 32'(e.cnt == 0));
                chk({e.nm, " we"}, 32'(we), 32'(e.we));
                chk({e.nm, " peek1_valid"}, 32'(peek1_valid), 32'(e.pk));
                if (e.wa  >= 0) chk({e.nm, " w_addr"}, 32'(w_addr), 32'(e.wa));
                if (e.ra0 >= 0) chk({e.nm, " r_addr0"}, 32'(r_addr0), 32'(e.ra0));
                if (e.d0  >= 0) chk({e.nm, " r_data0"}, 32'(r_data0), 32'(e.d0));
                if (e.d1  >= 0) chk({e.nm, " r_data1"}, 32'(r_data1), 32'(e.d1));
`ifdef FIFO_CTRL_OVF_FLAGS_EN
                chk({e.nm, " ovf"}, 32'(ovf), 32'(e.ovf));
                chk({e.nm, " udf"}, 32'(udf), 32'(e.udf));
`else
                chk({e.nm, " ovf"}, 32'(ovf), 32'd0);
                chk({e.nm, " udf"}, 32'(udf), 32'd0);
`endif
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL watchdog actual=timeout required=finish");
            $fatal(1, "timeout");
        end
    end

    // Driver
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'hEE;
        reset = 1'b1; wr = 1'b0; rd = 1'b0; rd2 = 1'b0; w_data = 8'h00;
        repeat (2) @(posedge clk);

        st("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, X, X, 0, 0);

        // Fill to full; head+1 slot is written on the 2nd push -> bubble.
        for (int k = 0; k < 8; k++)
            st("push", 0, 1, 0, 0, 'h10 + k, k, 1, (k >= 3) ? 1 : 0, k, 0,
               (k >= 1) ? 'h10 : X, (k >= 3) ? 'h11 : X, 0, 0);
        st("push_full", 0, 1, 0, 0, 'h18, 8, 0, 1, 0, 0, 'h10, 'h11, 0, 0);

        // Drain one at a time, then pop an empty FIFO.
        for (int j = 0; j < 8; j++)
            st("pop1", 0, 0, 1, 0, 0, 8 - j, 0, (j <= 6) ? 1 : 0, 0, j, 'h10 + j,
               (j <= 6) ? ('h11 + j) : X, 1, 0);
        st("pop_empty", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, X, X, 1, 0);

        // Fill 4, idle, two pop-two cycles.
        for (int k = 0; k < 4; k++)
            st("fill4", 0, 1, 0, 0, 'h20 + k, k, 1, (k >= 3) ? 1 : 0, k, 0,
               (k >= 1) ? 'h20 : X, (k >= 3) ? 'h21 : X, 1, 1);
        st("idle", 0, 0, 0, 0, 0, 4, 0, 1, 4, 0, 'h20, 'h21, 1, 1);
        st("pop2a", 0, 0, 0, 1, 0, 4, 0, 1, 4, 0, 'h20, 'h21, 1, 1);
        st("pop2b", 0, 0, 0, 1, 0, 2, 0, 1, 4, 2, 'h22, 'h23, 1, 1);

        // count=1, push with rd2: pop rejected, write hits head+1 -> bubble.
        st("push_e", 0, 1, 0, 0, 'h30, 0, 1, 0, 4, 4, X, X, 1, 1);
        st("push_rd2", 0, 1, 0, 1, 'h31, 1, 1, 0, 5, 4, 'h30, X, 1, 1);
        st("bubble", 0, 0, 0, 0, 0, 2, 0, 0, 6, 4, 'h30, X, 1, 1);
        st("peek_ok", 0, 0, 0, 0, 0, 2, 0, 1, 6, 4, 'h30, 'h31, 1, 1);

        // Refill to full across the pointer wrap.
        for (int k = 0; k < 6; k++)
            st("refill", 0, 1, 0, 0, 'h32 + k, 2 + k, 1, 1, (6 + k) % 8, 4,
               'h30, 'h31, 1, 1);

        // Full FIFO, wr+rd for 10 cycles: data order preserved through wrap.
        for (int i = 0; i < 10; i++)
            st("full_wrrd", 0, 1, 1, 0, 'h40 + i, 8, 1, 1, (4 + i) % 8, (4 + i) % 8,
               seq(i), seq(i + 1), 1, 1);

        // Drain to count=5, then reset mid-stream (with wr held high).
        for (int i = 0; i < 3; i++)
            st("drain", 0, 0, 1, 0, 0, 8 - i, 0, 1, 6, (6 + i) % 8,
               seq(10 + i), seq(11 + i), 1, 1);
        st("rst_mid", 1, 1, 0, 0, 'h5F, 5, 0, 1, 6, 1, seq(13), seq(14), 1, 1);

        // Empty FIFO with wr+rd: push accepted, pop rejected.
        st("wr_rd_empty", 0, 1, 1, 0, 'h50, 0, 1, 0, 0, 0, X, X, 0, 0);
        st("after", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 'h50, X, 0, 1);

        @(negedge clk);
        reset = 1'b0; wr = 1'b0; rd = 1'b0; rd2 = 1'b0;
        #3;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        stim_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
